// File: rtl/muldiv_issue_ctrl_if.sv
// Signal bundle between the mul/div issue controller and its neighbours
// (decode, the RV32M unit u_muldiv, and the register-file write port).
interface muldiv_issue_ctrl_if;
  // Handshakes: an op moves to the unit on a cycle with md_valid_o=1 and
  // md_stall_i=0, and the controller holds md_inst_o/md_ra_o/md_rb_o steady
  // until then. A writeback completes on a cycle with wb_valid_o=1 and
  // wb_ack_i=1, and wb_rd_o/wb_data_o stay steady until then.
  logic        dec_valid_i;
  logic        dec_is_muldiv_i;
  logic [2:0]  dec_funct3_i;
  logic [4:0]  dec_rd_i;
  logic [31:0] dec_ra_i;
  logic [31:0] dec_rb_i;
  logic        flush_i;
  logic        pipe_stall_o;
  logic        busy_o;
  logic        md_valid_o;
  logic [7:0]  md_inst_o;
  logic [31:0] md_ra_o;
  logic [31:0] md_rb_o;
  logic        md_stall_i;
  logic        md_ready_i;
  logic [31:0] md_result_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_ack_i;
  logic        err_timeout_o;
  logic [1:0]  dbg_state;

  modport master (
    input  dec_valid_i, dec_is_muldiv_i, dec_funct3_i, dec_rd_i, dec_ra_i, dec_rb_i,
    input  flush_i, md_stall_i, md_ready_i, md_result_i, wb_ack_i,
    output pipe_stall_o, busy_o, md_valid_o, md_inst_o, md_ra_o, md_rb_o,
    output wb_valid_o, wb_rd_o, wb_data_o, err_timeout_o, dbg_state
  );

  modport slave (
    output dec_valid_i, dec_is_muldiv_i, dec_funct3_i, dec_rd_i, dec_ra_i, dec_rb_i,
    output flush_i, md_stall_i, md_ready_i, md_result_i, wb_ack_i,
    input  pipe_stall_o, busy_o, md_valid_o, md_inst_o, md_ra_o, md_rb_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, err_timeout_o, dbg_state
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Issue/retire controller around the RV32M mul/div unit: latches an op from
// decode, hands it to the unit, waits for the result and writes it back.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  muldiv_issue_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    funct3_q;
  logic [4:0]    rd_q;
  logic [31:0]   ra_q, rb_q, data_q;
  logic          kill_q, err_q;
  logic          accept, handshake, timeout_hit, kill_set;

  assign accept      = bus.dec_valid_i & bus.dec_is_muldiv_i & ~bus.flush_i;
  assign handshake   = (state_q == ISSUE) & ~bus.md_stall_i;
  assign timeout_hit = (state_q == WAIT) & ~bus.md_ready_i &
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  // Once the unit has the op, a flush can only discard its result.
  assign kill_set    = bus.flush_i & (handshake | (state_q == WAIT));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        if (!bus.md_stall_i)   state_d = WAIT;
        else if (bus.flush_i)  state_d = IDLE;
      end
      WAIT: begin
        if (bus.md_ready_i) begin
          if ((rd_q == 5'd0) || kill_q || bus.flush_i) state_d = IDLE;
          else                                         state_d = WB;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      WB:    if (bus.wb_ack_i || bus.flush_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      data_q   <= '0;
      kill_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if ((state_q == IDLE) && accept) begin
        funct3_q <= bus.dec_funct3_i;
        rd_q     <= bus.dec_rd_i;
        ra_q     <= bus.dec_ra_i;
        rb_q     <= bus.dec_rb_i;
        kill_q   <= 1'b0;
      end else if (kill_set) begin
        kill_q <= 1'b1;
      end
      if (handshake)              cnt_q <= '0;
      else if (state_q == WAIT)   cnt_q <= cnt_q + CW'(1);
      if ((state_q == WAIT) && bus.md_ready_i) data_q <= bus.md_result_i;
    end
  end

  assign bus.busy_o        = (state_q != IDLE);
  assign bus.pipe_stall_o  = (state_q != IDLE);
  assign bus.md_valid_o    = (state_q == ISSUE);
  assign bus.md_inst_o     = (state_q == ISSUE) ? (8'b1 << funct3_q) : 8'b0;
  assign bus.md_ra_o       = ra_q;
  assign bus.md_rb_o       = rb_q;
  assign bus.wb_valid_o    = (state_q == WB);
  assign bus.wb_rd_o       = rd_q;
  assign bus.wb_data_o     = data_q;
  assign bus.err_timeout_o = err_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Randomised bench for muldiv_issue_ctrl: the bench plays decode, the mul/div
// unit and the regfile port; a monitor checks issues and writebacks.
module tb_muldiv_issue_ctrl;

  localparam int TO = 8;

  localparam int M_NONE     = 0;
  localparam int M_FL_STALL = 1;
  localparam int M_FL_HS    = 2;
  localparam int M_FL_WAIT  = 3;
  localparam int M_FL_WB    = 4;
  localparam int M_RST_WB   = 5;
  localparam int M_TIMEOUT  = 6;

  logic clk;
  logic rst_n;

  muldiv_issue_ctrl_if bus();

  muldiv_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_to_exp = 0;
  int n_to_seen = 0;

  logic [71:0] iss_q[$];   // {one-hot inst, ra, rb}
  logic [36:0] exp_q[$];   // {rd, data}

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_busy(input logic b);
    check("busy", 64'(bus.busy_o), 64'(b));
    check("pipe_stall", 64'(bus.pipe_stall_o), 64'(b));
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    ref_result = '0;
    case (f3)
      3'd0: begin p = 64'(sa * sb); ref_result = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); ref_result = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); ref_result = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); ref_result = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = a;
        else ref_result = 32'(ia / ib);
      end
      3'd5: ref_result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
        else ref_result = 32'(ia % ib);
      end
      default: ref_result = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] ra,
                        input logic [31:0] rb, input int n_stall, input int lat,
                        input int ack_dly, input int mode, input int fl_k);
    logic [31:0] res;
    logic [7:0]  oh;
    bit          killed;
    res = ref_result(f3, ra, rb);
    oh = '0;
    oh[f3] = 1'b1;
    killed = (mode == M_FL_HS);

    next_cycle();
    bus.flush_i         = 1'b0;
    bus.dec_valid_i     = 1'b1;
    bus.dec_is_muldiv_i = 1'b1;
    bus.dec_funct3_i    = f3;
    bus.dec_rd_i        = rd;
    bus.dec_ra_i        = ra;
    bus.dec_rb_i        = rb;
    iss_q.push_back({oh, ra, rb});
    @(negedge clk);
    expect_busy(1'b0);

    next_cycle();
    bus.dec_valid_i  = 1'b0;
    bus.dec_ra_i     = $urandom();
    bus.dec_rb_i     = $urandom();
    bus.dec_funct3_i = 3'($urandom_range(0, 7));
    for (int i = 0; i < n_stall; i++) begin
      bus.md_stall_i  = 1'b1;
      bus.md_ready_i  = 1'($urandom_range(0, 1));
      if (mode == M_FL_STALL) bus.flush_i = 1'b1;
      @(negedge clk);
      check("issue_valid", 64'(bus.md_valid_o), 64'd1);
      expect_busy(1'b1);
      next_cycle();
      bus.flush_i    = 1'b0;
      bus.md_ready_i = 1'b0;
      if (mode == M_FL_STALL) begin
        bus.md_stall_i = 1'b0;
        void'(iss_q.pop_front());
        @(negedge clk);
        expect_busy(1'b0);
        check("flush_stall_no_valid", 64'(bus.md_valid_o), 64'd0);
        return;
      end
    end

    bus.md_stall_i = 1'b0;
    if (mode == M_FL_HS) bus.flush_i = 1'b1;
    @(negedge clk);
    check("issue_valid", 64'(bus.md_valid_o), 64'd1);
    next_cycle();
    bus.flush_i = 1'b0;

    for (int k = 0; k < TO; k++) begin
      if (mode == M_FL_WAIT && k == fl_k) begin
        bus.flush_i = 1'b1;
        killed = 1'b1;
      end
      bus.md_stall_i = 1'($urandom_range(0, 1));
      if (mode != M_TIMEOUT && k == lat) begin
        bus.md_ready_i  = 1'b1;
        bus.md_result_i = res;
      end else begin
        bus.md_result_i = $urandom();
      end
      @(negedge clk);
      check("wait_valid", 64'(bus.md_valid_o), 64'd0);
      check("wait_inst", 64'(bus.md_inst_o), 64'd0);
      check("wait_wb_valid", 64'(bus.wb_valid_o), 64'd0);
      expect_busy(1'b1);
      next_cycle();
      bus.flush_i    = 1'b0;
      bus.md_ready_i = 1'b0;
      bus.md_stall_i = 1'b0;
      if (mode != M_TIMEOUT && k == lat) break;
      if (mode == M_TIMEOUT && k == TO - 1) begin
        n_to_exp++;
        @(negedge clk);
        check("timeout_pulse", 64'(bus.err_timeout_o), 64'd1);
        check("timeout_no_wb", 64'(bus.wb_valid_o), 64'd0);
        expect_busy(1'b0);
        next_cycle();
        @(negedge clk);
        check("timeout_pulse_end", 64'(bus.err_timeout_o), 64'd0);
        return;
      end
    end

    if (rd == 5'd0 || killed) begin
      @(negedge clk);
      check("dropped_no_wb", 64'(bus.wb_valid_o), 64'd0);
      expect_busy(1'b0);
      return;
    end

    if (mode == M_NONE) exp_q.push_back({rd, res});
    for (int a = 0; a <= ack_dly; a++) begin
      bus.wb_ack_i = (a == ack_dly) ? 1'b1 : 1'b0;
      if (mode == M_FL_WB && a == ack_dly) bus.flush_i = 1'b1;
      if (mode == M_RST_WB && a == ack_dly) begin
        bus.wb_ack_i = 1'b0;
        #2;
        check("wb_before_reset", 64'(bus.wb_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        check("rst_md_valid", 64'(bus.md_valid_o), 64'd0);
        check("rst_pipe_stall", 64'(bus.pipe_stall_o), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        expect_busy(1'b0);
        return;
      end
      @(negedge clk);
      check("wb_valid", 64'(bus.wb_valid_o), 64'd1);
      check("wb_rd_hold", 64'(bus.wb_rd_o), 64'(rd));
      check("wb_data_hold", 64'(bus.wb_data_o), 64'(res));
      expect_busy(1'b1);
      next_cycle();
      bus.wb_ack_i = 1'b0;
      bus.flush_i  = 1'b0;
    end
    @(negedge clk);
    check("wb_valid_after", 64'(bus.wb_valid_o), 64'd0);
    expect_busy(1'b0);
  endtask

  // Idle cycles with decode traffic that must not be accepted.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      bus.flush_i = 1'b0;
      case ($urandom_range(0, 2))
        0: begin bus.dec_valid_i = 1'b0; bus.dec_is_muldiv_i = 1'($urandom_range(0, 1)); end
        1: begin bus.dec_valid_i = 1'b1; bus.dec_is_muldiv_i = 1'b0; end
        default: begin bus.dec_valid_i = 1'b1; bus.dec_is_muldiv_i = 1'b1; bus.flush_i = 1'b1; end
      endcase
      bus.dec_funct3_i = 3'($urandom_range(0, 7));
      bus.dec_rd_i     = 5'($urandom_range(1, 31));
      bus.dec_ra_i     = $urandom();
      @(negedge clk);
      expect_busy(1'b0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: pick_operand = 32'd0;
      1: pick_operand = 32'hFFFF_FFFF;
      2: pick_operand = 32'h8000_0000;
      default: pick_operand = $urandom();
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [71:0] ei;
    logic [36:0] ew;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.md_valid_o) begin
          check("inst_onehot", 64'($onehot(bus.md_inst_o)), 64'd1);
          check("issue_expected", 64'(iss_q.size() != 0), 64'd1);
          if (iss_q.size() != 0) begin
            ei = iss_q[0];
            check("issue_inst", 64'(bus.md_inst_o), 64'(ei[71:64]));
            check("issue_ra", 64'(bus.md_ra_o), 64'(ei[63:32]));
            check("issue_rb", 64'(bus.md_rb_o), 64'(ei[31:0]));
            if (!bus.md_stall_i) void'(iss_q.pop_front());
          end
        end
        if (bus.wb_valid_o && bus.wb_ack_i && !bus.flush_i) begin
          check("wb_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            ew = exp_q.pop_front();
            check("wb_rd", 64'(bus.wb_rd_o), 64'(ew[36:32]));
            check("wb_data", 64'(bus.wb_data_o), 64'(ew[31:0]));
          end
        end
        if (bus.err_timeout_o) n_to_seen++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int mode, n_stall, lat, ack_dly, fl_k;
    logic [4:0] rd;
    rst_n = 1'b0;
    bus.dec_valid_i = 1'b0;   bus.dec_is_muldiv_i = 1'b0;
    bus.dec_funct3_i = '0;    bus.dec_rd_i = '0;
    bus.dec_ra_i = '0;        bus.dec_rb_i = '0;
    bus.flush_i = 1'b0;       bus.md_stall_i = 1'b0;
    bus.md_ready_i = 1'b0;    bus.md_result_i = '0;
    bus.wb_ack_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_busy(1'b0);
    check("reset_md_valid", 64'(bus.md_valid_o), 64'd0);
    check("reset_md_inst", 64'(bus.md_inst_o), 64'd0);
    check("reset_md_ra", 64'(bus.md_ra_o), 64'd0);
    check("reset_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    check("reset_wb_data", 64'(bus.wb_data_o), 64'd0);
    check("reset_err", 64'(bus.err_timeout_o), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    idle_cycles(2);

    run_op(3'd0, 5'd5, 32'd3, 32'd7, 0, 1, 0, M_NONE, 0);            // MUL latency
    run_op(3'd5, 5'd12, 32'd100, 32'd7, 3, 4, 1, M_NONE, 0);         // DIVU with issue stall
    run_op(3'd6, 5'd0, 32'h0000_DEAD, 32'd3, 0, 2, 0, M_NONE, 0);    // rd = x0
    run_op(3'd0, 5'd7, 32'd11, 32'd13, 0, 1, 0, M_FL_WAIT, 0);       // flush in WAIT
    run_op(3'd1, 5'd8, 32'hFFFF_FFF0, 32'd9, 0, 0, 0, M_NONE, 0);    // next op normal
    run_op(3'd1, 5'd3, 32'd1, 32'd2, 0, 0, 0, M_TIMEOUT, 0);         // timeout
    run_op(3'd2, 5'd4, 32'd5, 32'd6, 0, TO - 1, 0, M_NONE, 0);       // ready on last cycle
    run_op(3'd4, 5'd6, 32'd50, 32'd0, 2, 1, 0, M_FL_STALL, 0);       // flush while stalled
    run_op(3'd7, 5'd9, 32'd50, 32'd7, 0, 2, 0, M_FL_HS, 0);          // flush at handshake
    run_op(3'd3, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1, M_FL_WB, 0);
    run_op(3'd4, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 2, 2, M_RST_WB, 0);
    run_op(3'd0, 5'd13, 32'd6, 32'd7, 0, 0, 0, M_NONE, 0);           // back to back after reset

    for (int n = 0; n < 80; n++) begin
      rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      n_stall = $urandom_range(0, 3);
      lat     = $urandom_range(0, TO - 1);
      ack_dly = $urandom_range(0, 3);
      fl_k    = 0;
      case ($urandom_range(0, 9))
        5: begin mode = M_FL_STALL; if (n_stall == 0) n_stall = 1; end
        6: mode = M_FL_HS;
        7: begin mode = M_FL_WAIT; if (lat == 0) lat = 1; fl_k = $urandom_range(0, lat - 1); end
        8: mode = M_FL_WB;
        9: mode = M_TIMEOUT;
        default: mode = M_NONE;
      endcase
      run_op(3'($urandom_range(0, 7)), rd, pick_operand(), pick_operand(),
             n_stall, lat, ack_dly, mode, fl_k);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    check("issue_q_drained", 64'(iss_q.size()), 64'd0);
    check("wb_q_drained", 64'(exp_q.size()), 64'd0);
    check("timeout_count", 64'(n_to_seen), 64'(n_to_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Issue/retire controller directly upstream and downstream of the RV32M mul/div unit (u_muldiv) in the CPU.
- Accepts M-extension ops from decode, stalls the pipeline, and drives the unit's valid/one-hot-op/operand inputs while respecting its stall.
- Waits for the unit's ready, captures the result, and presents a register-file writeback with the destination register.
- Handles flush, rd==x0 and a hang timeout.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT before abort; legal range 4..1023.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dec_valid_i  in  1  decode has a valid instruction
- dec_is_muldiv_i  in  1  instruction is RV32M
- dec_funct3_i  in  3  RV32M funct3
- dec_rd_i  in  5  destination register
- dec_ra_i  in  32  rs1 value
- dec_rb_i  in  32  rs2 value
- flush_i  in  1  pipeline flush (branch/trap)
- pipe_stall_o  out  1  stall decode/fetch
- busy_o  out  1  controller not IDLE
- md_valid_o  out  1  to unit valid_i
- md_inst_o  out  8  one-hot {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}; bit i = (funct3==i)
- md_ra_o  out  32  to operand_ra_i
- md_rb_o  out  32  to operand_rb_i
- md_stall_i  in  1  from unit stall_o
- md_ready_i  in  1  from unit ready_o
- md_result_i  in  32  from unit result_o
- wb_valid_o  out  1  writeback request
- wb_rd_o  out  5  writeback register
- wb_data_o  out  32  writeback data
- wb_ack_i  in  1  regfile write port granted
- err_timeout_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_ni=0, async): state IDLE; all outputs 0; internal registers, kill flag and counter cleared. Reset mid-operation abandons the op with no writeback.
- States: IDLE, ISSUE, WAIT, WB. busy_o = pipe_stall_o = (state != IDLE). All outputs are registered or decoded from state only.
- IDLE:
  - dec_valid_i & dec_is_muldiv_i & !flush_i latches funct3, rd and operands, then moves to ISSUE.
  - Otherwise the controller stays in IDLE.
- ISSUE:
  - md_valid_o=1; md_inst_o and md_ra_o/md_rb_o come from latched registers and are stable while held.
  - md_stall_i=0: handshake completes this cycle; go to WAIT and clear the counter.
  - md_stall_i=1: stay in ISSUE holding all values.
  - md_ready_i is ignored.
- WAIT:
  - md_valid_o=0, md_inst_o=0. The counter increments each cycle.
  - md_ready_i=1: capture md_result_i into wb_data.
    - If rd==0 or kill is set: go to IDLE with no writeback.
    - Otherwise: go to WB.
  - Counter == TIMEOUT_CYCLES-1 with no ready: pulse err_timeout_o next cycle, go to IDLE, discard the op.
- WB:
  - wb_valid_o=1 with wb_rd_o/wb_data_o held stable until wb_ack_i=1.
  - On ack, go to IDLE; wb_valid_o is 0 the following cycle.
- Flush:
  - IDLE: the accept that cycle is suppressed.
  - ISSUE with md_stall_i=1: go straight to IDLE, because the unit never started.
  - ISSUE with md_stall_i=0, or WAIT: set kill, continue to wait for md_ready_i (or timeout), then go to IDLE without writeback.
  - WB: go to IDLE without writeback, even if wb_ack_i=1 in the same cycle.
- Latency, no stall, MUL completing at start+2:
  - Accept at cycle T.
  - md_valid_o at T+1.
  - md_ready_i at T+3.
  - wb_valid_o at T+4.
- Width: counter is clog2(TIMEOUT_CYCLES) bits and saturates only through the abort.
- Exactly one md_inst_o bit is high whenever md_valid_o=1.
- No back-to-back issue: the next accept happens no earlier than one cycle after returning to IDLE.

Test Plan:
- MUL: funct3=000, rd=5, ra=3, rb=7, no stall, ready at T+3 with result 21 -> md_inst_o=8'h01 at T+1; wb_valid_o at T+4 with rd=5, data=21; pipe_stall_o high T+1..T+4 and low after ack.
- DIVU issue stall: funct3=101, md_stall_i=1 for 3 cycles -> md_valid_o held 4 cycles with md_inst_o=8'h20 and operands unchanged; WAIT entered only after stall drops.
- rd=x0 REM: ready with result 0xDEAD -> no wb_valid_o; IDLE the cycle after ready.
- Flush in WAIT: flush_i pulsed at T+2, ready at T+3 -> wb_valid_o never asserted; IDLE at T+4; the next op is accepted normally.
- Timeout: TIMEOUT_CYCLES=8, md_ready_i never asserted -> err_timeout_o single pulse after 8 WAIT cycles, IDLE, no writeback.
- Reset mid-WB: wb_valid_o=1, wb_ack_i=0, rst_ni driven low asynchronously -> wb_valid_o, md_valid_o and pipe_stall_o 0 immediately, with no clock edge needed.
